// File: rtl/alu_iter.sv
// alu_iter: registered execute unit for the multi-cycle CPU.
// Single-cycle ops finish one clock after the start edge. MUL (shift-add)
// and signed DIV (restoring, on magnitudes) iterate WIDTH cycles.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   alu_en_i        start request, accepted on its rising edge while idle
//   alu_op_i        operation code
//   op2_dir_i       operand-2 source: rs2 / U-imm / sign-extended I-imm / zero
//   rs1_data_i      operand 1
//   rs2_data_i      register operand 2
//   instr_i         IR contents, source of the immediates
//   result_o        registered result, changes only on completion or reset
//   result_valid_o  one-cycle completion pulse
//   busy_o          high while a MUL/DIV iteration is in progress
module alu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alu_en_i,
    input  logic [7:0]       alu_op_i,
    input  logic [1:0]       op2_dir_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [31:0]      instr_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    typedef enum logic [7:0] {
        OP_ADD  = 8'd0,  OP_ADDI = 8'd1,  OP_SUB = 8'd2,  OP_MUL = 8'd3,
        OP_DIV  = 8'd4,  OP_SLL  = 8'd5,  OP_SRL = 8'd6,  OP_AND = 8'd7,
        OP_OR   = 8'd8,  OP_NOT  = 8'd9,  OP_XOR = 8'd10, OP_LUI = 8'd11
    } op_t;

    state_t           state_q, state_d;
    logic             en_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;      // MUL: shifted multiplicand, DIV: divisor magnitude
    logic [WIDTH-1:0] b_q;      // MUL: shifted multiplier,   DIV: dividend -> quotient
    logic [WIDTH-1:0] acc_q;    // MUL: partial product,      DIV: partial remainder
    logic             neg_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] op1, op2, op1_mag, op2_mag, single_res;
    logic             start, is_mul, is_div, div_zero, div_ovf, last;
    logic [WIDTH-1:0] mul_acc_nx, rem_nx, quot_nx, quot_res;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic             unused_instr;

    assign unused_instr = ^instr_i[11:0];

    assign op1 = rs1_data_i;

    always_comb begin
        op2 = '0;
        case (op2_dir_i)
            2'b00:   op2 = rs2_data_i;
            2'b01:   op2 = WIDTH'({instr_i[31:12], 12'b0});
            2'b10:   op2 = {{(WIDTH-12){instr_i[31]}}, instr_i[31:20]};
            default: op2 = '0;
        endcase
    end

    assign start    = alu_en_i & ~en_q & (state_q == S_IDLE);
    assign is_mul   = (alu_op_i == OP_MUL);
    assign is_div   = (alu_op_i == OP_DIV);
    assign div_zero = (op2 == '0);
    assign div_ovf  = (op1 == MIN_INT) && (op2 == '1);
    assign op1_mag  = op1[WIDTH-1] ? -op1 : op1;
    assign op2_mag  = op2[WIDTH-1] ? -op2 : op2;
    assign last     = (cnt_q == CW'(WIDTH-1));

    always_comb begin
        single_res = '0;
        case (alu_op_i)
            OP_ADD, OP_ADDI: single_res = op1 + op2;
            OP_SUB:          single_res = op1 - op2;
            OP_SLL:          single_res = op1 << op2[CW-1:0];
            OP_SRL:          single_res = op1 >> op2[CW-1:0];
            OP_AND:          single_res = op1 & op2;
            OP_OR:           single_res = op1 | op2;
            OP_NOT:          single_res = ~op1;
            OP_XOR:          single_res = op1 ^ op2;
            OP_LUI:          single_res = op2;
            // only reached for the two DIV cases that skip iteration
            OP_DIV:          single_res = div_zero ? '1 : MIN_INT;
            default:         single_res = '0;
        endcase
    end

    // One iteration step of each algorithm.
    assign mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);
    assign div_shift  = {acc_q, b_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, a_q};
    assign div_ge     = ~div_diff[WIDTH];
    assign rem_nx     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quot_nx    = {b_q[WIDTH-2:0], div_ge};
    assign quot_res   = neg_q ? -quot_nx : quot_nx;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (is_mul)                              state_d = S_MUL;
                else if (is_div && !(div_zero || div_ovf)) state_d = S_DIV;
                else                                     state_d = S_DONE;
            end
            S_MUL, S_DIV: if (last) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        result_valid_o = (state_q == S_DONE);
        busy_o         = (state_q == S_MUL) || (state_q == S_DIV);
    end

    assign result_o = result_q;

    // Datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            en_q <= alu_en_i;
            if (start) begin
                cnt_q <= '0;
                acc_q <= '0;
                if (is_mul) begin
                    a_q <= op1;
                    b_q <= op2;
                end else if (is_div && !(div_zero || div_ovf)) begin
                    a_q   <= op2_mag;
                    b_q   <= op1_mag;
                    neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
                end else begin
                    result_q <= single_res;
                end
            end else if (state_q == S_MUL) begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= mul_acc_nx;
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
                if (last) result_q <= mul_acc_nx;
            end else if (state_q == S_DIV) begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= rem_nx;
                b_q   <= quot_nx;
                if (last) result_q <= quot_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter: one task per scenario.
module tb_alu_iter;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        alu_en  = 1'b0;
    logic [7:0]  alu_op  = 8'd0;
    logic [1:0]  op2_dir = 2'b00;
    logic [31:0] rs1     = '0;
    logic [31:0] rs2     = '0;
    logic [31:0] instr   = '0;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .alu_en_i       (alu_en),
        .alu_op_i       (alu_op),
        .op2_dir_i      (op2_dir),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .instr_i        (instr),
        .result_o       (result),
        .result_valid_o (result_valid),
        .busy_o         (busy)
    );

    // Drive a one-cycle alu_en pulse; returns at the negedge after the start edge.
    task automatic pulse_start(input logic [7:0] op, input logic [1:0] dir,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ins);
        @(negedge clk);
        alu_op = op; op2_dir = dir; rs1 = a; rs2 = b; instr = ins;
        alu_en = 1'b1;
        @(negedge clk);
        alu_en = 1'b0;
    endtask

    // Follow an iterative op until busy drops (bounded), gathering counts.
    task automatic wait_iter(input logic [31:0] hold, output int nbusy,
                             output int nearly, output int nchg);
        nbusy = 0; nearly = 0; nchg = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (result_valid !== 1'b0) nearly++;
            if (result !== hold) nchg++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        pulse_start(8'd0, 2'b00, 32'd5, 32'd7, 32'h0);
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected %h", result, 32'd12); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b expected 0", result_valid); end
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL add_hold: got %h expected %h", result, 32'd12); end
    endtask

    task automatic test_single_ops;
        logic [7:0]  v_op  [10] = '{8'd2, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd9, 8'd12, 8'd0, 8'd1};
        logic [1:0]  v_dir [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10};
        logic [31:0] v_a   [10] = '{32'd5, 32'd1, 32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                    32'hF0F0_F0F0, 32'h0000_FFFF, 32'd5, 32'h1234, 32'd1};
        logic [31:0] v_b   [10] = '{32'd7, 32'd33, 32'd31, 32'hFF00_FF00, 32'hFF00_FF00,
                                    32'hFF00_FF00, 32'd0, 32'd7, 32'd7, 32'd0};
        logic [31:0] v_ins [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FF0_0000};
        logic [31:0] v_exp [10] = '{32'hFFFF_FFFE, 32'd2, 32'd1, 32'hF000_F000, 32'hFFF0_FFF0,
                                    32'h0FF0_0FF0, 32'hFFFF_0000, 32'h0, 32'h1234, 32'h800};
        for (int i = 0; i < 10; i++) begin
            pulse_start(v_op[i], v_dir[i], v_a[i], v_b[i], v_ins[i]);
            checks++; if (result !== v_exp[i]) begin errors++; $display("FAIL single_op[%0d] op=%0d: got %h expected %h", i, v_op[i], result, v_exp[i]); end
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, result_valid); end
        end
    endtask

    task automatic test_addi_lui;
        pulse_start(8'd1, 2'b10, 32'd10, 32'hDEAD_BEEF, 32'hFFD0_0000);
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL addi_result: got %h expected %h", result, 32'd7); end
        pulse_start(8'd11, 2'b01, 32'hDEAD_BEEF, 32'h0, 32'h1234_5ABC);
        checks++; if (result !== 32'h1234_5000) begin errors++; $display("FAIL lui_result: got %h expected %h", result, 32'h1234_5000); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL lui_valid: got %b expected 1", result_valid); end
    endtask

    task automatic test_mul;
        int nb, ne, nc;
        pulse_start(8'd3, 2'b00, 32'hFFFF_FFFE, 32'd3, 32'h0);
        wait_iter(32'h1234_5000, nb, ne, nc);
        checks++; if (nb !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 32", nb); end
        checks++; if (ne !== 0) begin errors++; $display("FAIL mul_early_valid: got %0d expected 0", ne); end
        checks++; if (nc !== 0) begin errors++; $display("FAIL mul_result_hold: got %0d changes expected 0", nc); end
        checks++; if (result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_result: got %h expected %h", result, 32'hFFFF_FFFA); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b expected 1", result_valid); end
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_single: got %b expected 0", result_valid); end
        pulse_start(8'd3, 2'b00, 32'd1000, 32'd1000, 32'h0);
        wait_iter(32'hFFFF_FFFA, nb, ne, nc);
        checks++; if (result !== 32'h000F_4240) begin errors++; $display("FAIL mul_1000sq: got %h expected %h", result, 32'h000F_4240); end
    endtask

    task automatic test_div;
        int nb, ne, nc;
        pulse_start(8'd4, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h0);
        wait_iter(32'h000F_4240, nb, ne, nc);
        checks++; if (nb !== 32) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 32", nb); end
        checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_2: got %h expected %h", result, 32'hFFFF_FFFD); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL div_valid: got %b expected 1", result_valid); end
        pulse_start(8'd4, 2'b00, 32'd7, 32'd0, 32'h0);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h expected %h", result, 32'hFFFF_FFFF); end
        checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL div_by_zero_timing: got valid=%b busy=%b expected valid=1 busy=0", result_valid, busy); end
        pulse_start(8'd4, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected %h", result, 32'h8000_0000); end
        checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL div_overflow_timing: got valid=%b busy=%b expected valid=1 busy=0", result_valid, busy); end
        pulse_start(8'd4, 2'b00, 32'd100, 32'hFFFF_FFF9, 32'h0);
        wait_iter(32'h8000_0000, nb, ne, nc);
        checks++; if (result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_neg7: got %h expected %h", result, 32'hFFFF_FFF2); end
    endtask

    task automatic test_start_filter;
        int nvalid;
        int nb, ne, nc;
        @(negedge clk);
        alu_op = 8'd0; op2_dir = 2'b00; rs1 = 32'd1; rs2 = 32'd2; alu_en = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) nvalid++;
            if (i == 4) alu_en = 1'b0;
        end
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL held_en_pulses: got %0d expected 1", nvalid); end
        checks++; if (result !== 32'd3) begin errors++; $display("FAIL held_en_result: got %h expected %h", result, 32'd3); end
        pulse_start(8'd3, 2'b00, 32'd1000, 32'd1000, 32'h0);
        repeat (5) @(negedge clk);
        alu_op = 8'd0; rs1 = 32'd9; rs2 = 32'd9; alu_en = 1'b1;
        @(negedge clk);
        alu_en = 1'b0;
        wait_iter(32'd3, nb, ne, nc);
        checks++; if (ne !== 0 || nc !== 0) begin errors++; $display("FAIL ignored_start_effect: got early=%0d changes=%0d expected 0 0", ne, nc); end
        checks++; if (result !== 32'h000F_4240) begin errors++; $display("FAIL ignored_start_result: got %h expected %h", result, 32'h000F_4240); end
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL ignored_start_extra_valid: got %0d expected 0", nvalid); end
    endtask

    task automatic test_reset_mid;
        pulse_start(8'd3, 2'b00, 32'd1000, 32'd1000, 32'h0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", result_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected %h", result, 32'h0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL postreset_idle: got busy=%b valid=%b expected 0 0", busy, result_valid); end
        pulse_start(8'd0, 2'b00, 32'd5, 32'd7, 32'h0);
        checks++; if (result !== 32'd12 || result_valid !== 1'b1) begin errors++; $display("FAIL postreset_add: got %h valid=%b expected %h valid=1", result, result_valid, 32'd12); end
    endtask

    task automatic test_back_to_back;
        int nb, ne, nc;
        pulse_start(8'd4, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h0);
        wait_iter(32'd12, nb, ne, nc);
        checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_div: got %h expected %h", result, 32'hFFFF_FFFD); end
        pulse_start(8'd0, 2'b00, 32'd20, 32'd22, 32'h0);
        checks++; if (result !== 32'd42 || result_valid !== 1'b1) begin errors++; $display("FAIL b2b_add: got %h valid=%b expected %h valid=1", result, result_valid, 32'd42); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_single_ops();
        test_addi_lui();
        test_mul();
        test_div();
        test_start_filter();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
